// File: rtl/alu_op_sequencer_if.sv
// Request/response bundle between the control unit and the ALU op sequencer.
// The control unit (master) issues start/op/abort; the sequencer (slave)
// answers with the handshake status, the one-hot ALU select and the Z-load,
// done and err strobes.
interface alu_op_sequencer_if #(
  parameter int SIG_COUNT = 13,
  parameter int OP_BITS   = 4
);

  logic                 start;
  logic [OP_BITS-1:0]   op;
  logic                 abort;
  logic                 ready;
  logic                 busy;
  logic [SIG_COUNT-1:0] ctrl_signal;
  logic                 z_load;
  logic                 done;
  logic                 err;

  modport master (
    output start,
    output op,
    output abort,
    input  ready,
    input  busy,
    input  ctrl_signal,
    input  z_load,
    input  done,
    input  err
  );

  modport slave (
    input  start,
    input  op,
    input  abort,
    output ready,
    output busy,
    output ctrl_signal,
    output z_load,
    output done,
    output err
  );

endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU sequencer. Accepts one opcode per start/ready handshake,
// holds the one-hot ALU select for an opcode-dependent settle time so the
// long multiply/divide paths can resolve, pulses the Z (HI/LO) load and then
// reports completion. Illegal opcodes skip the ALU and complete with err.
// Every output is a flop: the next-state logic also computes the next output
// values, so outputs change exactly on the edge that enters a state.
module alu_op_sequencer #(
  parameter int SIG_COUNT    = 13,
  parameter int OP_BITS      = 4,
  parameter int BASIC_CYCLES = 1,
  parameter int MUL_CYCLES   = 4,
  parameter int DIV_CYCLES   = 8
) (
  input logic                clk,
  input logic                clr,
  alu_op_sequencer_if.slave  bus
);

  // Longest settle time sets the counter width; the counter holds L-1.
  localparam int MAX_AB  = (BASIC_CYCLES > MUL_CYCLES) ? BASIC_CYCLES : MUL_CYCLES;
  localparam int MAX_CYC = (MAX_AB > DIV_CYCLES) ? MAX_AB : DIV_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0]   BASIC_LOAD = CNT_W'(BASIC_CYCLES - 1);
  localparam logic [CNT_W-1:0]   MUL_LOAD   = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0]   DIV_LOAD   = CNT_W'(DIV_CYCLES - 1);
  localparam logic [OP_BITS-1:0] OP_MUL     = OP_BITS'(2);
  localparam logic [OP_BITS-1:0] OP_DIV     = OP_BITS'(3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OP_BITS-1:0]   op_q, op_d;

  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic [SIG_COUNT-1:0] ctrl_q, ctrl_d;
  logic                 z_load_q, z_load_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 op_legal;
  logic [CNT_W-1:0]     load_val;

  // Opcode decode for the request currently on the bus.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case statements leaves a variable unassigned (no latch).
    load_val = BASIC_LOAD;
    op_legal = (32'(bus.op) < 32'(SIG_COUNT));
    if (bus.op == OP_MUL) begin
      load_val = MUL_LOAD;
    end else if (bus.op == OP_DIV) begin
      load_val = DIV_LOAD;
    end
  end

  // Next state, settle counter, latched opcode and next output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // start wins over a simultaneous abort; abort means nothing here.
        if (bus.start) begin
          op_d = bus.op;
          if (op_legal) begin
            cnt_d   = load_val;
            state_d = S_EXEC;
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_EXEC: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_WRITE: begin
        // The z_load of this cycle is already in its flop; abort only
        // suppresses the completion pulse.
        state_d = bus.abort ? S_IDLE : S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d  = (state_d == S_IDLE);
    busy_d   = (state_d == S_EXEC) || (state_d == S_WRITE);
    ctrl_d   = busy_d ? (SIG_COUNT'(1) << op_d) : '0;
    z_load_d = (state_d == S_WRITE);
    done_d   = (state_d == S_DONE);
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples the pre-edge values regardless of statement order.
    if (clr) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      ctrl_q   <= '0;
      z_load_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      ctrl_q   <= ctrl_d;
      z_load_q <= z_load_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.ready       = ready_q;
  assign bus.busy        = busy_q;
  assign bus.ctrl_signal = ctrl_q;
  assign bus.z_load      = z_load_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer. dut_a uses default settle times,
// dut_b uses BASIC_CYCLES=3 for the clear-during-EXEC scenario.
module tb_alu_op_sequencer;

  logic clk;
  logic clr_a;
  logic clr_b;

  int checks;
  int errors;

  alu_op_sequencer_if #(.SIG_COUNT(13), .OP_BITS(4)) bus_a ();
  alu_op_sequencer_if #(.SIG_COUNT(13), .OP_BITS(4)) bus_b ();

  alu_op_sequencer #(
    .SIG_COUNT(13), .OP_BITS(4), .BASIC_CYCLES(1), .MUL_CYCLES(4), .DIV_CYCLES(8)
  ) dut_a (
    .clk (clk),
    .clr (clr_a),
    .bus (bus_a.slave)
  );

  alu_op_sequencer #(
    .SIG_COUNT(13), .OP_BITS(4), .BASIC_CYCLES(3), .MUL_CYCLES(4), .DIV_CYCLES(8)
  ) dut_b (
    .clk (clk),
    .clr (clr_b),
    .bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr_a = 1'b1;
    clr_b = 1'b1;
    bus_a.start = 1'b0; bus_a.op = 4'd0; bus_a.abort = 1'b0;
    bus_b.start = 1'b0; bus_b.op = 4'd0; bus_b.abort = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus_a.ready, bus_a.busy, bus_a.z_load, bus_a.done, bus_a.err} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags: got %b required 10000",
               {bus_a.ready, bus_a.busy, bus_a.z_load, bus_a.done, bus_a.err});
    end
    checks++;
    if (bus_a.ctrl_signal !== 13'h0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %h required 0000", bus_a.ctrl_signal);
    end
    clr_a = 1'b0;
    clr_b = 1'b0;
    tick();
  endtask

  task automatic test_add();
    bus_a.op = 4'd0;
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    checks++;
    if (bus_a.ctrl_signal !== 13'h0001 || bus_a.busy !== 1'b1 || bus_a.ready !== 1'b0) begin
      errors++;
      $display("FAIL add_exec: ctrl=%h busy=%b ready=%b required 0001/1/0",
               bus_a.ctrl_signal, bus_a.busy, bus_a.ready);
    end
    tick();
    checks++;
    if (bus_a.ctrl_signal !== 13'h0001 || bus_a.z_load !== 1'b1) begin
      errors++;
      $display("FAIL add_write: ctrl=%h z_load=%b required 0001/1", bus_a.ctrl_signal, bus_a.z_load);
    end
    tick();
    checks++;
    if (bus_a.done !== 1'b1 || bus_a.err !== 1'b0 || bus_a.ctrl_signal !== 13'h0000 ||
        bus_a.z_load !== 1'b0) begin
      errors++;
      $display("FAIL add_done: done=%b err=%b ctrl=%h z_load=%b required 1/0/0000/0",
               bus_a.done, bus_a.err, bus_a.ctrl_signal, bus_a.z_load);
    end
    tick();
    checks++;
    if (bus_a.ready !== 1'b1 || bus_a.done !== 1'b0) begin
      errors++;
      $display("FAIL add_ready: ready=%b done=%b required 1/0", bus_a.ready, bus_a.done);
    end
  endtask

  task automatic test_mul();
    bus_a.op = 4'd2;
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus_a.ctrl_signal !== 13'h0004 || bus_a.z_load !== (i == 4) || bus_a.done !== 1'b0) begin
        errors++;
        $display("FAIL mul_hold[%0d]: ctrl=%h z_load=%b done=%b required 0004/%b/0",
                 i, bus_a.ctrl_signal, bus_a.z_load, bus_a.done, (i == 4));
      end
      tick();
    end
    checks++;
    if (bus_a.done !== 1'b1 || bus_a.err !== 1'b0 || bus_a.ctrl_signal !== 13'h0000) begin
      errors++;
      $display("FAIL mul_done: done=%b err=%b ctrl=%h required 1/0/0000",
               bus_a.done, bus_a.err, bus_a.ctrl_signal);
    end
    tick();
  endtask

  task automatic test_div_abort();
    bus_a.op = 4'd3;
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    tick();
    tick();
    checks++;
    if (bus_a.ctrl_signal !== 13'h0008) begin
      errors++;
      $display("FAIL div_exec3: ctrl=%h required 0008", bus_a.ctrl_signal);
    end
    bus_a.abort = 1'b1;
    tick();
    bus_a.abort = 1'b0;
    checks++;
    if (bus_a.ctrl_signal !== 13'h0000 || bus_a.ready !== 1'b1 || bus_a.busy !== 1'b0 ||
        bus_a.z_load !== 1'b0 || bus_a.done !== 1'b0) begin
      errors++;
      $display("FAIL div_abort: ctrl=%h ready=%b busy=%b z_load=%b done=%b required 0000/1/0/0/0",
               bus_a.ctrl_signal, bus_a.ready, bus_a.busy, bus_a.z_load, bus_a.done);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (bus_a.z_load !== 1'b0 || bus_a.done !== 1'b0 || bus_a.ready !== 1'b1) begin
        errors++;
        $display("FAIL div_after_abort[%0d]: z_load=%b done=%b ready=%b required 0/0/1",
                 i, bus_a.z_load, bus_a.done, bus_a.ready);
      end
    end
  endtask

  task automatic test_abort_write();
    bus_a.op = 4'd8;
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    tick();
    bus_a.abort = 1'b1;
    checks++;
    if (bus_a.z_load !== 1'b1 || bus_a.ctrl_signal !== 13'h0100) begin
      errors++;
      $display("FAIL and_write: z_load=%b ctrl=%h required 1/0100", bus_a.z_load, bus_a.ctrl_signal);
    end
    tick();
    bus_a.abort = 1'b0;
    checks++;
    if (bus_a.done !== 1'b0 || bus_a.ready !== 1'b1 || bus_a.ctrl_signal !== 13'h0000 ||
        bus_a.z_load !== 1'b0) begin
      errors++;
      $display("FAIL write_abort: done=%b ready=%b ctrl=%h z_load=%b required 0/1/0000/0",
               bus_a.done, bus_a.ready, bus_a.ctrl_signal, bus_a.z_load);
    end
  endtask

  task automatic test_abort_start_idle();
    bus_a.op = 4'd1;
    bus_a.start = 1'b1;
    bus_a.abort = 1'b1;
    tick();
    bus_a.start = 1'b0;
    bus_a.abort = 1'b0;
    checks++;
    if (bus_a.ctrl_signal !== 13'h0002 || bus_a.busy !== 1'b1) begin
      errors++;
      $display("FAIL start_wins: ctrl=%h busy=%b required 0002/1", bus_a.ctrl_signal, bus_a.busy);
    end
    tick();
    tick();
    checks++;
    if (bus_a.done !== 1'b1) begin
      errors++;
      $display("FAIL sub_done: done=%b required 1", bus_a.done);
    end
    tick();
  endtask

  task automatic test_illegal();
    bus_a.op = 4'd13;
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    checks++;
    if (bus_a.done !== 1'b1 || bus_a.err !== 1'b1 || bus_a.ctrl_signal !== 13'h0000 ||
        bus_a.z_load !== 1'b0 || bus_a.ready !== 1'b0 || bus_a.busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal_done: done=%b err=%b ctrl=%h z_load=%b ready=%b busy=%b required 1/1/0000/0/0/0",
               bus_a.done, bus_a.err, bus_a.ctrl_signal, bus_a.z_load, bus_a.ready, bus_a.busy);
    end
    tick();
    checks++;
    if (bus_a.ready !== 1'b1 || bus_a.done !== 1'b0 || bus_a.err !== 1'b0 || bus_a.z_load !== 1'b0) begin
      errors++;
      $display("FAIL illegal_ready: ready=%b done=%b err=%b z_load=%b required 1/0/0/0",
               bus_a.ready, bus_a.done, bus_a.err, bus_a.z_load);
    end
  endtask

  task automatic test_back_to_back();
    bus_a.op = 4'd2;
    bus_a.start = 1'b1;
    tick();
    // Keep requesting with a changing opcode while the multiply runs.
    for (int i = 0; i < 5; i++) begin
      bus_a.op = (i % 2 == 0) ? 4'd3 : 4'd7;
      checks++;
      if (bus_a.ctrl_signal !== 13'h0004 || bus_a.ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_hold[%0d]: ctrl=%h ready=%b required 0004/0",
                 i, bus_a.ctrl_signal, bus_a.ready);
      end
      tick();
    end
    bus_a.op = 4'd5;
    checks++;
    if (bus_a.done !== 1'b1 || bus_a.ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: done=%b ready=%b required 1/0", bus_a.done, bus_a.ready);
    end
    tick();
    bus_a.op = 4'd0;
    checks++;
    if (bus_a.ready !== 1'b1 || bus_a.busy !== 1'b0 || bus_a.ctrl_signal !== 13'h0000) begin
      errors++;
      $display("FAIL b2b_idle: ready=%b busy=%b ctrl=%h required 1/0/0000",
               bus_a.ready, bus_a.busy, bus_a.ctrl_signal);
    end
    tick();
    bus_a.start = 1'b0;
    checks++;
    if (bus_a.ctrl_signal !== 13'h0001) begin
      errors++;
      $display("FAIL b2b_second: ctrl=%h required 0001", bus_a.ctrl_signal);
    end
    tick();
    tick();
    tick();
    checks++;
    if (bus_a.ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_drain: ready=%b required 1", bus_a.ready);
    end
  endtask

  task automatic test_clr_exec();
    bus_b.op = 4'd12;
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    checks++;
    if (bus_b.ctrl_signal !== 13'h1000 || bus_b.busy !== 1'b1) begin
      errors++;
      $display("FAIL incpc_exec1: ctrl=%h busy=%b required 1000/1", bus_b.ctrl_signal, bus_b.busy);
    end
    tick();
    clr_b = 1'b1;
    tick();
    clr_b = 1'b0;
    checks++;
    if ({bus_b.ready, bus_b.busy, bus_b.z_load, bus_b.done, bus_b.err} !== 5'b10000 ||
        bus_b.ctrl_signal !== 13'h0000) begin
      errors++;
      $display("FAIL clr_exec: flags=%b ctrl=%h required 10000/0000",
               {bus_b.ready, bus_b.busy, bus_b.z_load, bus_b.done, bus_b.err}, bus_b.ctrl_signal);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus_b.z_load !== 1'b0 || bus_b.done !== 1'b0 || bus_b.ready !== 1'b1) begin
        errors++;
        $display("FAIL clr_after[%0d]: z_load=%b done=%b ready=%b required 0/0/1",
                 i, bus_b.z_load, bus_b.done, bus_b.ready);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_mul();
    test_div_abort();
    test_abort_write();
    test_abort_start_idle();
    test_illegal();
    test_back_to_back();
    test_clr_exec();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Multi-cycle controller that sequences the shared datapath ALU for the control unit. It accepts one opcode per request over a start/ready handshake and drives the ALU's one-hot `ctrl_signal`, holding it stable for an opcode-dependent number of cycles so the long combinational multiply and divide paths can settle. It then pulses the 64-bit Z (HI/LO) register load and signals completion. It sits between the control unit and the ALU / Z-register enables on the bus datapath.

## Interface
- `SIG_COUNT`, 13: width of `ctrl_signal`; equals the number of ALU operations.
- `OP_BITS`, 4: opcode width.
- `BASIC_CYCLES`, 1: settle cycles for add, sub, shifts, rotates, and, or, negate, not, incPC. Must be ≥1.
- `MUL_CYCLES`, 4: settle cycles for multiply (op 2). Must be ≥1.
- `DIV_CYCLES`, 8: settle cycles for divide (op 3). Must be ≥1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `clr`  in  1  synchronous, active-high reset.
- `start`  in  1  request strobe; accepted only when `ready`=1.
- `op`  in  OP_BITS  opcode index 0..12 (0 add, 1 sub, 2 mul, 3 div, 4 shr, 5 shl, 6 ror, 7 rol, 8 and, 9 or, 10 neg, 11 not, 12 incPC).
- `abort`  in  1  synchronous cancel of an in-flight operation.
- `ready`  out  1  high only in IDLE.
- `busy`  out  1  high in EXEC and WRITE.
- `ctrl_signal`  out  SIG_COUNT  one-hot ALU select; all-zero when no operation is active.
- `z_load`  out  1  one-cycle load enable for both Z halves (HI and LO).
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  qualifies `done`; high when the opcode was illegal.

## Operation
- States: IDLE, EXEC, WRITE, DONE. All outputs are registered.
- IDLE: `ready`=1 and `ctrl_signal`=0.
  - On `start`: latch `op` into `op_q`.
  - If `op` ≤ 12, load the settle counter with L−1 and go to EXEC. L = MUL_CYCLES for op 2, DIV_CYCLES for op 3, BASIC_CYCLES otherwise.
  - If `op` ≥ 13, go directly to DONE with `err`=1. No ALU activity and no `z_load`.
- EXEC: `ctrl_signal` = 1 << `op_q`, held constant. The counter decrements each cycle. When the counter is 0, go to WRITE.
- WRITE: `ctrl_signal` is still held and `z_load`=1 for exactly this cycle. Then go to DONE.
- DONE: `done`=1, `err`=0 for legal ops, `ctrl_signal`=0. Then go to IDLE.
- `start` while `ready`=0 is ignored and is not queued. `op` is sampled only on the accepting edge; later changes to `op` have no effect.
- `abort` in EXEC or WRITE:
  - Next state is IDLE; `ctrl_signal`=0 and `z_load`=0 from the next cycle.
  - No `done` pulse is produced.
  - If `abort` coincides with the WRITE cycle, that `z_load` still occurs (it is already registered).
- `abort` in IDLE or DONE has no effect. `abort` and `start` together in IDLE: `start` wins.
- `clr` overrides everything, in any state: next state is IDLE, the counter is 0, and `op_q` is 0.
- `ctrl_signal` is never multi-hot and never changes value during EXEC or WRITE of one operation.

## Timing
- Reset values: `ready`=1, `busy`=0, `ctrl_signal`=0, `z_load`=0, `done`=0, `err`=0.
- `start` is accepted at edge k. EXEC spans cycles k+1 .. k+L, WRITE is at k+L+1, DONE is at k+L+2, and `ready` returns at k+L+3.
- The ALU select is stable for L+1 cycles before and including the Z load edge.
- Illegal op accepted at edge k: `done`=`err`=1 in cycle k+1, and `ready` returns at k+2.
- Maximum throughput is one operation per L+3 cycles.
- The counter width is clog2 of max(BASIC_CYCLES, MUL_CYCLES, DIV_CYCLES), minimum 1 bit.

## Test plan
- After `clr`: op=0 (add) with `start` at edge 1.
  - Required: `ctrl_signal`=13'h0001 in cycle 2; `z_load`=1 in cycle 3; `done`=1, `err`=0 in cycle 4; `ready`=1 in cycle 5.
- op=2 (mul), default parameters.
  - Required: `ctrl_signal`=13'h0004 for exactly 5 consecutive cycles (4 EXEC + WRITE); `z_load` only in the 5th; `done` in the following cycle.
- op=3 (div) with `abort` in the 3rd EXEC cycle.
  - Required: `ctrl_signal`=0 next cycle; no `z_load`; no `done`; `ready`=1.
- op=13 (illegal).
  - Required: `done`=`err`=1 one cycle after acceptance; `ctrl_signal` stays 0; `z_load` never asserts.
- `start` re-asserted every cycle during a mul, with `op` toggling.
  - Required: only the first request is executed, `ctrl_signal` stays 13'h0004 throughout, and a new request is accepted only once `ready`=1.
- `clr` asserted in the 2nd EXEC cycle of op=12 (incPC, with BASIC_CYCLES set to 3).
  - Required: all outputs at reset values in the next cycle; no `z_load`; no `done`.
